pll_lock_monitor: RTL
=====================

// Module: pll_lock_monitor
// PURPOSE
//  Receive-side checker for derived clocks such as the PseudoPll output.
//  Samples a slow clock-like input (sig_in) in the clk_in domain and measures the
//  rising-edge-to-rising-edge period in clk_in cycles. Compares the period against a
//  nominal window and reports lock/loss. Sits beside the clock generator in
//  system-level benches and in RTL as a health monitor.
// PARAMETERS
//  CNT_W      16   width of period counter/output
//  NOMINAL    100  expected period, clk_in cycles
//  TOL        2    allowed deviation; good = NOMINAL-TOL <= period <= NOMINAL+TOL
//  LOCK_COUNT 4    consecutive good periods required to lock (>=1)
//  TIMEOUT    200  cycles without a rising edge -> signal lost (TIMEOUT < 2**CNT_W-1)
// PORTS
//  clk_in        in   1      system clock; all logic on rising edge
//  rst_n         in   1      asynchronous, active-low reset
//  sig_in        in   1      monitored signal, asynchronous to clk_in
//  period        out  CNT_W  last measured period, clk_in cycles
//  period_valid  out  1      1-cycle pulse when period updates
//  locked        out  1      high while in LOCKED state
//  lost          out  1      1-cycle pulse on LOCKED -> not LOCKED
//  err_sticky    out  1      (PLL_MON_STICKY_EN only) see CONFIGURATION
//  err_clr       in   1      (PLL_MON_STICKY_EN only) see CONFIGURATION
// BEHAVIOUR
//  - Reset (rst_n=0, async): all outputs 0, state IDLE, cnt=0, good_cnt=0, sync flops 0.
//  - sig_in -> 2-flop synchronizer (s1,s2) + history flop s3; rise = s2 & ~s3.
//    Edge on sig_in is seen as rise 2-3 clk_in cycles later.
//  - Counter: on rise cnt<=1; else cnt<=cnt+1, saturating at 2**CNT_W-1.
//    Rises N cycles apart measure exactly N.
//  - States: IDLE, ACQUIRE, LOCKED.
//    IDLE: on rise -> ACQUIRE, good_cnt=0; no period_valid (no reference edge yet).
//    ACQUIRE: on rise: period<=cnt, period_valid=1 next cycle.
//      good: good_cnt++; if good_cnt+1==LOCK_COUNT -> LOCKED.
//      bad: good_cnt=0, stay ACQUIRE.
//    LOCKED: on rise: period/period_valid as above.
//      good: stay.
//      bad: -> ACQUIRE, good_cnt=0, lost pulse.
//  - locked is registered: rises in the same cycle as the period_valid of the
//    LOCK_COUNT-th good period; falls with the lost pulse.
//  - Timeout: no rise and cnt>=TIMEOUT in ACQUIRE/LOCKED -> IDLE, good_cnt=0;
//    lost pulses if leaving LOCKED.
//  - Rise and timeout in the same cycle: rise wins. Period is judged normally.
//  - period holds its last value until the next valid measurement (not cleared on
//    timeout).
//  - lost and period_valid are single-cycle pulses and never stretch.
// CONFIGURATION
//  - PLL_MON_STICKY_EN defined: adds err_sticky/err_clr.
//    err_sticky sets on any bad period or timeout while in ACQUIRE/LOCKED.
//    err_clr=1 clears it next cycle; a set event in the same cycle wins over clear.
//  - Undefined: the ports and logic are absent; all other behaviour is identical.
// TESTING (NOMINAL=100, TOL=2, LOCK_COUNT=4, TIMEOUT=200)
//  - sig_in square wave, period 100, 6 rises -> 5 period_valid pulses, period=100;
//    locked=1 with 4th pulse.
//  - Period 103 constant -> period=103 every pulse; locked stays 0; lost never pulses.
//  - Locked, then one period 90, then period 100 -> lost pulse + locked=0 at the 90
//    measurement; relock on 4th following good.
//  - Locked, sig_in held low 250 cycles -> lost pulse at cnt=200, state IDLE.
//    Next rise gives no period_valid; the following rise does.
//  - rst_n low mid-period while locked -> locked/period/pulses 0 immediately,
//    without waiting for clk_in. After release, needs 1+LOCK_COUNT rises to relock.
//  - PLL_MON_STICKY_EN: bad period 97 -> err_sticky=1, remains through relock;
//    err_clr pulse -> 0. Build without the macro must also pass the tests above.

Source files
------------

// File: rtl/pll_lock_monitor_if.sv
// ----------------------------------------------------------------------------
// pll_lock_monitor_if
//   Interface that groups the monitored signal and the lock-monitor results.
//   Build option: PLL_MON_STICKY_EN adds the sticky error flag and its clear.
//   Signals:
//     sig_in       monitored clock-like signal (asynchronous to clk_in)
//     period       last measured rise-to-rise period, clk_in cycles
//     period_valid 1-cycle pulse when period updates
//     locked       high while the monitor is locked
//     lost         1-cycle pulse when lock is lost
//     err_sticky   (PLL_MON_STICKY_EN) sticky bad-period/timeout flag
//     err_clr      (PLL_MON_STICKY_EN) clears err_sticky
//   Modports: master = the monitor, slave = the environment around it.
// ----------------------------------------------------------------------------
interface pll_lock_monitor_if #(
  parameter int unsigned CNT_W = 16
);
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             lost;
`ifdef PLL_MON_STICKY_EN
  logic             err_sticky;
  logic             err_clr;

  modport master (
    input  sig_in, err_clr,
    output period, period_valid, locked, lost, err_sticky
  );
  modport slave (
    output sig_in, err_clr,
    input  period, period_valid, locked, lost, err_sticky
  );
`else
  modport master (
    input  sig_in,
    output period, period_valid, locked, lost
  );
  modport slave (
    output sig_in,
    input  period, period_valid, locked, lost
  );
`endif
endinterface

// File: rtl/pll_lock_monitor.sv
// ----------------------------------------------------------------------------
// pll_lock_monitor
//   Measures the rising-edge period of a slow clock-like signal in clk_in
//   cycles and reports lock when LOCK_COUNT consecutive periods fall inside
//   NOMINAL +/- TOL. A missing edge for TIMEOUT cycles drops back to IDLE.
//   Build option: PLL_MON_STICKY_EN adds err_sticky/err_clr.
//   Ports:
//     clk_in  system clock, all logic on rising edge
//     rst_n   asynchronous active-low reset
//     mon     pll_lock_monitor_if.master (sig_in, period, period_valid,
//             locked, lost, optional err_sticky/err_clr)
// ----------------------------------------------------------------------------
module pll_lock_monitor #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned NOMINAL    = 100,
  parameter int unsigned TOL        = 2,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TIMEOUT    = 200
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  pll_lock_monitor_if.master   mon
);

  localparam int unsigned PER_LO = NOMINAL - TOL;
  localparam int unsigned PER_HI = NOMINAL + TOL;
  localparam int unsigned GC_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_e;

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GC_W-1:0]  good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             locked_q, locked_d;
  logic             lost_q, lost_d;

  logic rise_c;
  logic good_c;
  logic timeout_c;

  // Synchronised rising edge plus period classification of the running count
  assign rise_c    = s2_q & ~s3_q;
  assign good_c    = (cnt_q >= CNT_W'(PER_LO)) && (cnt_q <= CNT_W'(PER_HI));
  assign timeout_c = ~rise_c && (cnt_q >= CNT_W'(TIMEOUT));

  // State and output registers
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      cnt_q          <= '0;
      good_cnt_q     <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      lost_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      s1_q           <= mon.sig_in;
      s2_q           <= s1_q;
      s3_q           <= s2_q;
      cnt_q          <= cnt_d;
      good_cnt_q     <= good_cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      lost_q         <= lost_d;
    end
  end

  // Next-state, period counter and output decode
  always_comb begin
    state_d        = state_q;
    good_cnt_d     = good_cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    lost_d         = 1'b0;
    cnt_d          = cnt_q;

    if (rise_c)               cnt_d = CNT_W'(1);
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        // First edge only establishes the reference; nothing to measure yet
        if (rise_c) begin
          state_d    = ACQUIRE;
          good_cnt_d = '0;
        end
      end
      ACQUIRE, LOCKED: begin
        if (rise_c) begin
          period_d       = cnt_q;
          period_valid_d = 1'b1;
          if (good_c) begin
            if (state_q == ACQUIRE) begin
              if (good_cnt_q == GC_W'(LOCK_COUNT - 1)) state_d = LOCKED;
              else good_cnt_d = good_cnt_q + GC_W'(1);
            end
          end else begin
            state_d    = ACQUIRE;
            good_cnt_d = '0;
            lost_d     = (state_q == LOCKED);
          end
        end else if (timeout_c) begin
          state_d    = IDLE;
          good_cnt_d = '0;
          lost_d     = (state_q == LOCKED);
        end
      end
      default: begin
        state_d    = IDLE;
        good_cnt_d = '0;
      end
    endcase

    // locked mirrors the next state so it rises with the locking period_valid
    locked_d = (state_d == LOCKED);
  end

  assign mon.period       = period_q;
  assign mon.period_valid = period_valid_q;
  assign mon.locked       = locked_q;
  assign mon.lost         = lost_q;

`ifdef PLL_MON_STICKY_EN
  logic err_sticky_q, err_sticky_d;
  logic err_evt_c;

  // Bad period or timeout while measuring; a set beats a same-cycle clear
  always_comb begin
    err_evt_c    = (state_q != IDLE) && ((rise_c && !good_c) || timeout_c);
    err_sticky_d = err_sticky_q;
    if (err_evt_c)        err_sticky_d = 1'b1;
    else if (mon.err_clr) err_sticky_d = 1'b0;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) err_sticky_q <= 1'b0;
    else        err_sticky_q <= err_sticky_d;
  end

  assign mon.err_sticky = err_sticky_q;
`endif

endmodule
